jtbubl_rom_arb: RTL and testbench
=================================

Name: jtbubl_rom_arb

Overview:
- Shares the single SDRAM read port among four 8-bit ROM requesters: main, sub, MCU and sound.
- Each slot has a one-word (16-bit) cache with an address tag. A hit answers in zero cycles; a miss queues an SDRAM read.
- Round-robin arbitration, per-slot address offset, and byte-lane selection.
- Sits between the CPU ROM buses and the SDRAM controller; GFX keeps its own path.

Parameters:
- AW, 18, slot byte-address width. Narrower slots zero-extend their address.
- OFFSET0, 22'h0, word offset of slot 0 (main).
- OFFSET1, 22'h1_4000, word offset of slot 1 (sub).
- OFFSET2, 22'h1_C000, word offset of slot 2 (MCU).
- OFFSET3, 22'h1_8000, word offset of slot 3 (sound).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM load in progress; blocks and flushes the block.
- slotN_cs  in  1  (N=0..3) slot read request.
- slotN_addr  in  AW  slot byte address.
- slotN_ok  out  1  slot data valid for the current address.
- slotN_dout  out  8  slot data byte.
- sdram_req  out  1  SDRAM read request.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  SDRAM has accepted the request.
- data_rdy  in  1  data_read is valid this cycle.
- data_read  in  16  SDRAM read word.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE, sdram_req=0, sdram_addr=0.
  - All valid bits=0, tags=0, data=0; rr pointer=3, so slot 0 has first priority.
  - slotN_ok=0, slotN_dout=0.
- Cache per slot: valid, tag[AW-2:0], word[15:0].
- Hit and ok:
  - hitN = valid & (tag == slotN_addr[AW-1:1]).
  - slotN_ok = slotN_cs & hitN & ~downloading. Combinational, zero latency.
- Data byte:
  - slotN_dout = slotN_addr[0] ? word[15:8] : word[7:0].
  - Driven regardless of cs.
- A slot is pending when slotN_cs & ~hitN & ~downloading, and it is not the slot currently being served with a matching address.
- IDLE:
  - If any slot is pending, grant the first pending slot after the rr pointer, searching cyclically.
  - On grant: latch gnt, gtag=addr[AW-1:1], sdram_addr = OFFSETgnt + gtag (zero-extended, modulo 2^22), rr=gnt. Go to REQ and assert sdram_req at that same edge.
  - Only one grant per IDLE cycle.
- REQ:
  - sdram_req stays 1 until sdram_ack is sampled high.
  - At that edge: sdram_req=0, go to WAIT.
- WAIT:
  - On data_rdy: word[gnt]=data_read, tag[gnt]=gtag, valid[gnt]=1, go to IDLE.
  - If ack and data_rdy arrive in the same cycle while in REQ, take both: sdram_req=0, write the cache, go to IDLE.
- Latency, miss with the arbiter idle:
  - Request visible at cycle 0; sdram_req high from cycle 1.
  - Cache written at the data_rdy edge; slotN_ok high the cycle after.
  - A grant can occur again in the following IDLE cycle.
- Address changes while a slot is in flight:
  - The fill still writes the latched gtag.
  - ok stays 0 on mismatch, and the slot re-requests from IDLE.
- cs drops while in flight: the fill completes normally; no abort.
- downloading high:
  - All valid bits clear every cycle; all ok=0; no new grants.
  - A transaction in REQ or WAIT is dropped immediately: sdram_req=0, state=IDLE, no cache write.
- Fairness: every pending slot is served within 4 grants.
- sdram_addr holds its last value outside REQ.
- Simultaneous hit and fill on the same slot: the fill wins; ok reflects the new tag from the next cycle.

Test Plan:
- Reset, then slot0 cs with addr=0x00005; ack at +3 and data_rdy with 0xBEEF at +6:
  - sdram_req rises 1 cycle after cs; sdram_addr=0x000002.
  - slot0_ok rises the cycle after data_rdy; slot0_dout=0xBE.
  - Change addr to 0x00004: ok stays high, dout=0xEF, no new sdram_req.
- All four slots miss in the same cycle: grants go in order 0,1,2,3.
  - sdram_addr values 0x000000+t0, 0x014000+t1, 0x01C000+t2, 0x018000+t3.
  - With slot 0 re-missing after its fill, the next order is 1,2,3,0.
- ack and data_rdy in the same cycle: one REQ cycle, cache filled, sdram_req low the next cycle, no extra request.
- Slot1 addr changes from 0x100 to 0x200 during WAIT:
  - Fill tag is 0x80; slot1_ok stays 0.
  - A second request goes out with sdram_addr=0x014100.
- downloading pulses high during WAIT:
  - sdram_req=0 and IDLE next cycle; all ok=0.
  - A data_rdy arriving afterwards writes nothing; after downloading falls, the same address misses again.
- rstn asserted low mid-REQ:
  - sdram_req=0 immediately, without a clock edge.
  - All ok=0 after release.

Source files
------------

// File: rtl/jtbubl_rom_arb.sv
// jtbubl_rom_arb: shares one SDRAM read port among four 8-bit ROM slots,
// each fronted by a one-word tagged cache and served round-robin.
module jtbubl_rom_arb #(
    parameter int          AW      = 18,
    parameter logic [21:0] OFFSET0 = 22'h0,
    parameter logic [21:0] OFFSET1 = 22'h1_4000,
    parameter logic [21:0] OFFSET2 = 22'h1_C000,
    parameter logic [21:0] OFFSET3 = 22'h1_8000
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          downloading,
    input  logic          slot0_cs,
    input  logic [AW-1:0] slot0_addr,
    output logic          slot0_ok,
    output logic [7:0]    slot0_dout,
    input  logic          slot1_cs,
    input  logic [AW-1:0] slot1_addr,
    output logic          slot1_ok,
    output logic [7:0]    slot1_dout,
    input  logic          slot2_cs,
    input  logic [AW-1:0] slot2_addr,
    output logic          slot2_ok,
    output logic [7:0]    slot2_dout,
    input  logic          slot3_cs,
    input  logic [AW-1:0] slot3_addr,
    output logic          slot3_ok,
    output logic [7:0]    slot3_dout,
    output logic          sdram_req,
    output logic [21:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          data_rdy,
    input  logic [15:0]   data_read
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    state_t state, st_nxt;
    logic [AW-1:0] addr [4];
    logic [21:0]   offs [4];
    logic [7:0]    dout [4];
    logic [AW-2:0] tag  [4];
    logic [15:0]   word [4];
    logic [3:0]    cs, hit, ok, pending, valid;
    logic [AW-2:0] gtag;
    logic [1:0]    gnt, rr, sel;
    logic          fill;

    assign addr[0] = slot0_addr;
    assign addr[1] = slot1_addr;
    assign addr[2] = slot2_addr;
    assign addr[3] = slot3_addr;
    assign offs[0] = OFFSET0;
    assign offs[1] = OFFSET1;
    assign offs[2] = OFFSET2;
    assign offs[3] = OFFSET3;
    assign cs = {slot3_cs, slot2_cs, slot1_cs, slot0_cs};
    assign {slot3_ok, slot2_ok, slot1_ok, slot0_ok} = ok;
    assign slot0_dout = dout[0];
    assign slot1_dout = dout[1];
    assign slot2_dout = dout[2];
    assign slot3_dout = dout[3];

    // The slot already in flight for the same word must not queue a duplicate read
    always_comb begin
        hit     = '0;
        ok      = '0;
        pending = '0;
        for (int i = 0; i < 4; i++) begin
            hit[i]     = valid[i] && tag[i] == addr[i][AW-1:1];
            ok[i]      = cs[i] & hit[i] & ~downloading;
            dout[i]    = addr[i][0] ? word[i][15:8] : word[i][7:0];
            pending[i] = cs[i] & ~hit[i] & ~downloading &
                         ~(state != IDLE && gnt == 2'(i) && gtag == addr[i][AW-1:1]);
        end
    end

    // Scan downwards so the nearest pending slot after rr wins
    always_comb begin
        sel = rr;
        for (int k = 4; k >= 1; k--)
            if (pending[rr + 2'(k)]) sel = rr + 2'(k);
    end

    always_comb begin
        st_nxt = state;
        fill   = 1'b0;
        case (state)
            IDLE: st_nxt = |pending ? REQ : IDLE;
            REQ: begin
                st_nxt = sdram_ack ? (data_rdy ? IDLE : WAIT) : REQ;
                fill   = sdram_ack & data_rdy;
            end
            WAIT: begin
                st_nxt = data_rdy ? IDLE : WAIT;
                fill   = data_rdy;
            end
            default: st_nxt = IDLE;
        endcase
        if (downloading) begin
            st_nxt = IDLE;
            fill   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= st_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            gnt        <= '0;
            gtag       <= '0;
            rr         <= 2'd3;
            valid      <= '0;
            for (int i = 0; i < 4; i++) begin
                tag[i]  <= '0;
                word[i] <= '0;
            end
        end else begin
            sdram_req <= st_nxt == REQ;
            if (state == IDLE && |pending) begin
                gnt        <= sel;
                gtag       <= addr[sel][AW-1:1];
                rr         <= sel;
                sdram_addr <= offs[sel] + 22'(addr[sel][AW-1:1]);
            end
            for (int i = 0; i < 4; i++) begin
                if (fill && gnt == 2'(i)) begin
                    valid[i] <= 1'b1;
                    tag[i]   <= gtag;
                    word[i]  <= data_read;
                end
            end
            if (downloading) valid <= '0;
        end
    end
endmodule

// File: tb/tb_jtbubl_rom_arb.sv
// tb_jtbubl_rom_arb: directed stimulus with scoreboard queues for SDRAM
// requests and slot data, checked by an independent negedge monitor.
module tb_jtbubl_rom_arb;
    logic        clk = 1'b0, rstn = 1'b0, downloading = 1'b0;
    logic        slot0_cs = 1'b0, slot1_cs = 1'b0, slot2_cs = 1'b0, slot3_cs = 1'b0;
    logic [17:0] slot0_addr = '0, slot1_addr = '0, slot2_addr = '0, slot3_addr = '0;
    logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
    logic [7:0]  slot0_dout, slot1_dout, slot2_dout, slot3_dout;
    logic        sdram_req, sdram_ack = 1'b0, data_rdy = 1'b0;
    logic [21:0] sdram_addr;
    logic [15:0] data_read = '0;
    logic [3:0]  okv;
    logic [7:0]  doutv [4];
    int          total = 0, passed = 0;
    logic [21:0] req_q [$];
    logic [9:0]  data_q [$];

    jtbubl_rom_arb dut (
        .clk(clk), .rstn(rstn), .downloading(downloading),
        .slot0_cs(slot0_cs), .slot0_addr(slot0_addr), .slot0_ok(slot0_ok), .slot0_dout(slot0_dout),
        .slot1_cs(slot1_cs), .slot1_addr(slot1_addr), .slot1_ok(slot1_ok), .slot1_dout(slot1_dout),
        .slot2_cs(slot2_cs), .slot2_addr(slot2_addr), .slot2_ok(slot2_ok), .slot2_dout(slot2_dout),
        .slot3_cs(slot3_cs), .slot3_addr(slot3_addr), .slot3_ok(slot3_ok), .slot3_dout(slot3_dout),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read)
    );

    assign okv = {slot3_ok, slot2_ok, slot1_ok, slot0_ok};
    assign doutv[0] = slot0_dout;
    assign doutv[1] = slot1_dout;
    assign doutv[2] = slot2_dout;
    assign doutv[3] = slot3_dout;

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req();
        int n = 0;
        while (!sdram_req && n < 50) begin
            tick(1);
            n++;
        end
        if (!sdram_req) chk("req_timeout", 32'(sdram_req), 32'd1);
    endtask

    // Plays the SDRAM side: ack after ack_wait cycles, data rdy_wait cycles after ack
    task automatic serve(input int ack_wait, input int rdy_wait, input logic [15:0] d);
        wait_req();
        tick(ack_wait);
        sdram_ack = 1'b1;
        if (rdy_wait == 0) begin
            data_rdy  = 1'b1;
            data_read = d;
        end
        tick(1);
        sdram_ack = 1'b0;
        if (rdy_wait > 0) begin
            tick(rdy_wait - 1);
            data_rdy  = 1'b1;
            data_read = d;
            tick(1);
        end
        data_rdy = 1'b0;
    endtask

    // Monitor: every rising sdram_req and every rising slot ok consumes one expectation
    initial begin
        logic       prev_req = 1'b0;
        logic [3:0] prev_ok  = '0;
        forever begin
            @(negedge clk);
            if (sdram_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_req: got addr %h, expected no request", sdram_addr);
                end else chk("sdram_addr", 32'(sdram_addr), 32'(req_q.pop_front()));
            end
            for (int i = 0; i < 4; i++) begin
                if (okv[i] && !prev_ok[i]) begin
                    if (data_q.size() == 0) begin
                        total++;
                        $display("FAIL unexpected_ok: got slot %0d dout %h, expected none", i, doutv[i]);
                    end else chk("slot_data", {22'd0, 2'(i), doutv[i]}, 32'(data_q.pop_front()));
                end
            end
            prev_req = sdram_req;
            prev_ok  = okv;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_req", 32'(sdram_req), 0);
        chk("rst_addr", 32'(sdram_addr), 0);
        chk("rst_ok", 32'(okv), 0);
        chk("rst_dout", {doutv[0], doutv[1], doutv[2], doutv[3]}, 0);
        rstn = 1'b1;
        tick(1);
        // single miss, byte select, hit on the other byte
        req_q.push_back(22'h000002);
        data_q.push_back({2'd0, 8'hBE});
        slot0_cs = 1'b1;
        slot0_addr = 18'h00005;
        chk("t1_req_low", 32'(sdram_req), 0);
        tick(1);
        chk("t1_req_rise", 32'(sdram_req), 1);
        serve(1, 3, 16'hBEEF);
        chk("t1_ok", 32'(slot0_ok), 1);
        chk("t1_dout_hi", 32'(slot0_dout), 32'hBE);
        tick(1);
        slot0_addr = 18'h00004;
        #1;
        chk("t1_ok_lo", 32'(slot0_ok), 1);
        chk("t1_dout_lo", 32'(slot0_dout), 32'hEF);
        tick(3);
        // four simultaneous misses after reset, then slot 0 re-misses
        slot0_cs = 1'b0;
        rstn = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        chk("t2_ok_after_rst", 32'(okv), 0);
        req_q.push_back(22'h000008);
        req_q.push_back(22'h014010);
        req_q.push_back(22'h01C018);
        req_q.push_back(22'h018020);
        req_q.push_back(22'h000009);
        data_q.push_back({2'd0, 8'h34});
        data_q.push_back({2'd1, 8'h78});
        data_q.push_back({2'd2, 8'hBC});
        data_q.push_back({2'd3, 8'hF0});
        data_q.push_back({2'd0, 8'h21});
        slot0_addr = 18'h10;
        slot1_addr = 18'h20;
        slot2_addr = 18'h30;
        slot3_addr = 18'h40;
        {slot3_cs, slot2_cs, slot1_cs, slot0_cs} = 4'hF;
        serve(0, 1, 16'h1234);
        tick(1);
        slot0_addr = 18'h12;
        serve(0, 1, 16'h5678);
        serve(1, 1, 16'h9ABC);
        serve(0, 2, 16'hDEF0);
        serve(0, 1, 16'h4321);
        tick(2);
        chk("t2_all_ok", 32'(okv), 32'hF);
        // ack and data_rdy together
        req_q.push_back(22'h01C080);
        data_q.push_back({2'd2, 8'h77});
        slot2_addr = 18'h101;
        serve(0, 0, 16'h77AA);
        chk("t3_req_low", 32'(sdram_req), 0);
        chk("t3_ok", 32'(slot2_ok), 1);
        tick(3);
        // address change during WAIT
        req_q.push_back(22'h014080);
        slot1_addr = 18'h100;
        wait_req();
        sdram_ack = 1'b1;
        tick(1);
        sdram_ack = 1'b0;
        slot1_addr = 18'h200;
        tick(2);
        data_rdy = 1'b1;
        data_read = 16'h5555;
        tick(1);
        data_rdy = 1'b0;
        chk("t4_ok_mismatch", 32'(slot1_ok), 0);
        data_q.push_back({2'd1, 8'h55});
        slot1_addr = 18'h100;
        tick(1);
        req_q.push_back(22'h014100);
        data_q.push_back({2'd1, 8'h0E});
        slot1_addr = 18'h200;
        serve(1, 2, 16'h0F0E);
        tick(2);
        // downloading during WAIT
        {slot2_cs, slot1_cs, slot0_cs} = 3'b000;
        req_q.push_back(22'h018040);
        slot3_addr = 18'h80;
        wait_req();
        sdram_ack = 1'b1;
        tick(1);
        sdram_ack = 1'b0;
        downloading = 1'b1;
        #1;
        chk("t5_ok_dl", 32'(okv), 0);
        tick(1);
        chk("t5_req_dl", 32'(sdram_req), 0);
        req_q.push_back(22'h018040);
        data_q.push_back({2'd3, 8'hFE});
        downloading = 1'b0;
        data_rdy = 1'b1;
        data_read = 16'hDEAD;
        tick(1);
        data_rdy = 1'b0;
        chk("t5_no_write", 32'(slot3_ok), 0);
        serve(1, 1, 16'hCAFE);
        chk("t5_refill", 32'(slot3_dout), 32'hFE);
        tick(2);
        // asynchronous reset during REQ
        slot3_addr = 18'h82;
        wait_req();
        chk("t6_req_addr", 32'(sdram_addr), 32'h018041);
        rstn = 1'b0;
        #1;
        chk("t6_req_async", 32'(sdram_req), 0);
        slot3_cs = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        chk("t6_ok", 32'(okv), 0);
        chk("t6_addr", 32'(sdram_addr), 0);
        slot3_cs = 1'b1;
        #1;
        chk("t6_ok_cs", 32'(slot3_ok), 0);
        slot3_cs = 1'b0;
        tick(3);
        chk("req_q_empty", 32'(req_q.size()), 0);
        chk("data_q_empty", 32'(data_q.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
